// File: rtl/bank_stream_loader_if.sv
// ---------------------------------------------------------------------------
// bank_stream_loader_if
// Groups the byte-stream handshake and the shared bank write port of the
// bank stream loader.
//   in_valid / in_data / in_ready : byte stream from the SPI receive path
//   bank_csen                     : one-hot bank chip enable
//   wrenb / addr_b / data_b       : write strobe, address and data shared by all banks
// Modports:
//   master : the loader (consumes the stream, drives the bank write port)
//   slave  : the surroundings (stream source and banks)
// ---------------------------------------------------------------------------
interface bank_stream_loader_if #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_BANKS  = 8
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic [NUM_BANKS-1:0]  bank_csen;
   logic                  wrenb;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] data_b;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output bank_csen,
      output wrenb,
      output addr_b,
      output data_b
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  bank_csen,
      input  wrenb,
      input  addr_b,
      input  data_b
   );
endinterface

// File: rtl/bank_stream_loader.sv
// ---------------------------------------------------------------------------
// bank_stream_loader
// Fills the accelerator data-memory banks from a byte stream. Byte k of a load
// is written to bank (k mod NUM_BANKS) at address (k / NUM_BANKS). A load of
// words_per_bank words per bank is requested with a one-cycle start pulse;
// completion is reported with a one-cycle done pulse (plus err when the
// request is out of range).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : load request, sampled only while idle
//   words_per_bank  : words to write into each bank, sampled with start
//   bus (master)    : byte stream in, shared bank write port out
//   busy            : a load is in progress
//   done            : one-cycle completion pulse
//   err             : one-cycle reject pulse, coincident with done
// All outputs are registered.
// ---------------------------------------------------------------------------
module bank_stream_loader #(
   parameter int unsigned ADDR_WIDTH     = 13,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_BANKS      = 8,
   parameter int unsigned BANK_SEL_WIDTH = 3,
   parameter int unsigned BANK_DEPTH     = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] words_per_bank,
   bank_stream_loader_if.master  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // Byte counter must hold words_per_bank * NUM_BANKS.
   localparam int unsigned TOT_W = ADDR_WIDTH + BANK_SEL_WIDTH;

   localparam logic [ADDR_WIDTH-1:0]     DEPTH_LIM = ADDR_WIDTH'(BANK_DEPTH);
   localparam logic [BANK_SEL_WIDTH-1:0] LAST_BANK = BANK_SEL_WIDTH'(NUM_BANKS - 1);
   localparam logic [TOT_W-1:0]          TOT_ONE   = TOT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t                    state;
   logic [TOT_W-1:0]          total;
   logic [TOT_W-1:0]          count;
   logic [BANK_SEL_WIDTH-1:0] bank_idx;
   logic [ADDR_WIDTH-1:0]     word_addr;
   logic                      accept_c;

   // A byte is consumed when offered while the loader is ready.
   assign accept_c = bus.in_valid & bus.in_ready;

   // Load sequencer, counters and registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         total         <= '0;
         count         <= '0;
         bank_idx      <= '0;
         word_addr     <= '0;
         bus.in_ready  <= 1'b0;
         bus.bank_csen <= '0;
         bus.wrenb     <= 1'b0;
         bus.addr_b    <= '0;
         bus.data_b    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         // Strobes are single-cycle; addr_b/data_b keep their last value.
         bus.wrenb     <= 1'b0;
         bus.bank_csen <= '0;
         done          <= 1'b0;
         err           <= 1'b0;

         case (state)
            IDLE: begin
               // busy drops one cycle after the final write of a load.
               busy <= 1'b0;
               if (start) begin
                  if (words_per_bank == '0) begin
                     done <= 1'b1;
                  end else if (words_per_bank > DEPTH_LIM) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else begin
                     // NUM_BANKS is a power of two, so the product is a shift.
                     total        <= TOT_W'(words_per_bank) << BANK_SEL_WIDTH;
                     count        <= '0;
                     bank_idx     <= '0;
                     word_addr    <= '0;
                     bus.in_ready <= 1'b1;
                     busy         <= 1'b1;
                     state        <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (accept_c) begin
                  bus.wrenb     <= 1'b1;
                  bus.bank_csen <= NUM_BANKS'(1) << bank_idx;
                  bus.addr_b    <= word_addr;
                  bus.data_b    <= DATA_WIDTH'(bus.in_data);
                  bank_idx      <= bank_idx + BANK_SEL_WIDTH'(1);
                  if (bank_idx == LAST_BANK) begin
                     word_addr <= word_addr + ADDR_WIDTH'(1);
                  end
                  count <= count + TOT_ONE;
                  // Final byte: done lines up with the write it produces.
                  if (count == total - TOT_ONE) begin
                     done         <= 1'b1;
                     bus.in_ready <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end

            default: begin
               bus.in_ready <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bank_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_bank_stream_loader
// Self-checking bench for bank_stream_loader: a table of load requests with
// expected write counts / spans / error flags, plus hand-written sequences for
// idle offers, reset mid-load and back-to-back loads. A negedge monitor logs
// every bank write and checks the write-port invariants.
// ---------------------------------------------------------------------------
module tb_bank_stream_loader;
   localparam int unsigned AW    = 13;
   localparam int unsigned DW    = 8;
   localparam int unsigned NB    = 8;
   localparam int unsigned BW    = 3;
   localparam int unsigned DEPTH = 1024;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW-1:0] words_per_bank;
   logic          busy;
   logic          done;
   logic          err;

   bank_stream_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB)) bus ();

   bank_stream_loader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB),
      .BANK_SEL_WIDTH(BW), .BANK_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .words_per_bank(words_per_bank),
      .bus(bus), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int bank;
      int addr;
      int data;
   } wr_t;

   typedef struct {
      int wpb;
      bit stall;
      int mid_at;
      int exp_writes;
      int exp_err;
      int exp_span;
   } vec_t;

   int            compared = 0;
   int            failed   = 0;
   int            cyc      = 0;
   int            wr_cnt, done_cnt, err_cnt, first_wr, last_wr;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_data;
   wr_t           wlog[$];
   vec_t          vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      wlog.delete();
      wr_cnt   = 0;
      done_cnt = 0;
      err_cnt  = 0;
      first_wr = -1;
      last_wr  = -1;
   endtask

   always @(posedge clk) cyc++;

   // Write-port monitor.
   always @(negedge clk) begin
      if (bus.wrenb === 1'b1) begin
         int b;
         b = 0;
         for (int i = 0; i < NB; i++) if (bus.bank_csen[i]) b = i;
         chk("csen_onehot", 32'($onehot(bus.bank_csen)), 1);
         wlog.push_back('{bank: b, addr: int'(bus.addr_b), data: int'(bus.data_b)});
         wr_cnt++;
         if (first_wr < 0) first_wr = cyc;
         last_wr   = cyc;
         last_addr = bus.addr_b;
         last_data = bus.data_b;
      end else if (!rst) begin
         chk("idle_hold", 32'({bus.bank_csen, bus.addr_b, bus.data_b}),
             32'({8'h00, last_addr, last_data}));
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) begin
         err_cnt++;
         chk("err_with_done", 32'(done), 1);
      end
      if (rst) begin
         last_addr = '0;
         last_data = '0;
      end
   end

   // Compare n logged writes from index first against the interleave rule.
   task automatic check_log(input string name, input int first, input int n, input int base);
      int bad;
      int where;
      bad   = 0;
      where = -1;
      if (wlog.size() < first + n) begin
         bad = 1;
      end else begin
         for (int k = 0; k < n; k++) begin
            wr_t e;
            e = wlog[first + k];
            if (e.bank != k % NB || e.addr != k / NB || e.data != ((base + k) & 255)) begin
               bad++;
               if (where < 0) where = k;
            end
         end
      end
      chk({name, "/log_bad_entries"}, 32'(bad), 0);
      if (where >= 0)
         $display("  first bad write %0d: bank %0d addr %0d data 0x%0h", where,
                  wlog[first + where].bank, wlog[first + where].addr, wlog[first + where].data);
   endtask

   // Offer bytes base.. until n accepted; optional stall toggling and a start
   // pulse (words_per_bank=5) once mid_at bytes were accepted.
   task automatic stream(input int n, input bit stall, input int base, input int mid_at,
                         output int got);
      int   budget;
      bit   v;
      bit   mid_done;
      logic rdy;
      budget   = 0;
      v        = 1'b1;
      mid_done = 1'b0;
      got      = 0;
      while (got < n && budget < 4 * n + 20) begin
         bus.in_valid = stall ? v : 1'b1;
         bus.in_data  = DW'(base + got);
         if (mid_at >= 0 && got == mid_at && !mid_done) begin
            start          = 1'b1;
            words_per_bank = AW'(5);
            mid_done       = 1'b1;
         end else begin
            start = 1'b0;
         end
         rdy = bus.in_ready;
         @(posedge clk);
         if (bus.in_valid && rdy) got++;
         #1;
         budget++;
         v = ~v;
      end
      bus.in_valid = 1'b0;
      start        = 1'b0;
   endtask

   task automatic run_load(input string name, input vec_t v);
      int got;
      int n;
      n = v.exp_writes;
      clear_stats();
      start          = 1'b1;
      words_per_bank = AW'(v.wpb);
      bus.in_valid   = 1'b0;
      step();
      start = 1'b0;
      if (n == 0) begin
         chk({name, "/done"}, 32'(done), 1);
         chk({name, "/err"}, 32'(err), 32'(v.exp_err));
         chk({name, "/wrenb"}, 32'(bus.wrenb), 0);
         chk({name, "/busy"}, 32'(busy), 0);
         chk({name, "/in_ready"}, 32'(bus.in_ready), 0);
         step();
         chk({name, "/done_drop"}, 32'(done), 0);
         chk({name, "/err_drop"}, 32'(err), 0);
         step();
         chk({name, "/writes"}, 32'(wr_cnt), 0);
         chk({name, "/done_cnt"}, 32'(done_cnt), 1);
         chk({name, "/err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
      end else begin
         chk({name, "/busy_rise"}, 32'(busy), 1);
         chk({name, "/ready_rise"}, 32'(bus.in_ready), 1);
         chk({name, "/done_early"}, 32'(done), 0);
         stream(n, v.stall, 0, v.mid_at, got);
         chk({name, "/accepted"}, 32'(got), 32'(n));
         chk({name, "/last_wrenb"}, 32'(bus.wrenb), 1);
         chk({name, "/last_done"}, 32'(done), 1);
         chk({name, "/last_err"}, 32'(err), 0);
         chk({name, "/last_busy"}, 32'(busy), 1);
         chk({name, "/last_ready"}, 32'(bus.in_ready), 0);
         chk({name, "/last_csen"}, 32'(bus.bank_csen), 32'(1) << ((n - 1) % NB));
         chk({name, "/last_addr"}, 32'(bus.addr_b), 32'((n - 1) / NB));
         chk({name, "/last_data"}, 32'(bus.data_b), 32'((n - 1) & 255));
         step();
         chk({name, "/busy_fall"}, 32'(busy), 0);
         chk({name, "/done_drop"}, 32'(done), 0);
         chk({name, "/wrenb_drop"}, 32'(bus.wrenb), 0);
         step();
         chk({name, "/writes"}, 32'(wr_cnt), 32'(n));
         chk({name, "/done_cnt"}, 32'(done_cnt), 1);
         chk({name, "/err_cnt"}, 32'(err_cnt), 0);
         chk({name, "/span"}, 32'(last_wr - first_wr + 1), 32'(v.exp_span));
         check_log(name, 0, n, 0);
      end
   endtask

   initial begin
      int got;
      vec_t one;

      vecs[0] = '{wpb: 2,    stall: 1'b0, mid_at: -1, exp_writes: 16,   exp_err: 0, exp_span: 16};
      vecs[1] = '{wpb: 2,    stall: 1'b1, mid_at: -1, exp_writes: 16,   exp_err: 0, exp_span: 31};
      vecs[2] = '{wpb: 0,    stall: 1'b0, mid_at: -1, exp_writes: 0,    exp_err: 0, exp_span: 0};
      vecs[3] = '{wpb: 1025, stall: 1'b0, mid_at: -1, exp_writes: 0,    exp_err: 1, exp_span: 0};
      vecs[4] = '{wpb: 2,    stall: 1'b0, mid_at: 8,  exp_writes: 16,   exp_err: 0, exp_span: 16};
      vecs[5] = '{wpb: 1024, stall: 1'b0, mid_at: -1, exp_writes: 8192, exp_err: 0, exp_span: 8192};
      vecs[6] = '{wpb: 1,    stall: 1'b0, mid_at: -1, exp_writes: 8,    exp_err: 0, exp_span: 8};
      one = vecs[6];

      clear_stats();
      last_addr      = '0;
      last_data      = '0;
      rst            = 1'b1;
      start          = 1'b0;
      words_per_bank = '0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      step();
      step();
      chk("reset/outputs",
          32'({bus.in_ready, bus.bank_csen, bus.wrenb, busy, done, err}), 0);
      chk("reset/addr_data", 32'({bus.addr_b, bus.data_b}), 0);
      rst = 1'b0;

      // Bytes offered while idle are neither accepted nor written.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_offer/in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;
      step();
      chk("idle_offer/writes", 32'(wr_cnt), 0);

      for (int i = 0; i < 7; i++) run_load($sformatf("vec%0d", i), vecs[i]);

      // Reset after five accepted bytes; the byte on the reset edge is dropped.
      clear_stats();
      start          = 1'b1;
      words_per_bank = AW'(2);
      step();
      start = 1'b0;
      stream(5, 1'b0, 0, -1, got);
      chk("rst_mid/accepted", 32'(got), 5);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h05;
      rst          = 1'b1;
      step();
      chk("rst_mid/outputs",
          32'({bus.in_ready, bus.bank_csen, bus.wrenb, busy, done, err}), 0);
      chk("rst_mid/addr_data", 32'({bus.addr_b, bus.data_b}), 0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      step();
      step();
      chk("rst_mid/writes", 32'(wr_cnt), 5);
      chk("rst_mid/done_cnt", 32'(done_cnt), 0);
      check_log("rst_mid", 0, 5, 0);
      run_load("after_rst", one);

      // Back-to-back: new start in the cycle done is high.
      clear_stats();
      start          = 1'b1;
      words_per_bank = AW'(1);
      step();
      start = 1'b0;
      stream(8, 1'b0, 0, -1, got);
      chk("b2b/first_accepted", 32'(got), 8);
      chk("b2b/first_done", 32'(done), 1);
      start          = 1'b1;
      words_per_bank = AW'(1);
      step();
      start = 1'b0;
      chk("b2b/busy_again", 32'(busy), 1);
      chk("b2b/ready_again", 32'(bus.in_ready), 1);
      stream(8, 1'b0, 8, -1, got);
      chk("b2b/second_accepted", 32'(got), 8);
      step();
      step();
      chk("b2b/writes", 32'(wr_cnt), 16);
      chk("b2b/done_cnt", 32'(done_cnt), 2);
      check_log("b2b_first", 0, 8, 0);
      check_log("b2b_second", 8, 8, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
